// File: rtl/fetch_controller.sv
// Fetch sequencer for the MIPS core: drives PC advance/load, a req/ack imem port,
// and a one-entry instruction buffer toward decode with redirect/exception flushing.
module fetch_controller #(
  parameter logic [31:0] EXC_VECTOR = 32'h80000180,
  parameter int          MAX_WAIT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcAddress,
  output logic        count,
  output logic        shouldUseNewPC,
  output logic [31:0] newPC,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectTarget,
  input  logic        exception,
  output logic        instrValid,
  output logic [31:0] instr,
  output logic [31:0] instrPC,
  output logic        fetchTimeout
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH,
    S_HOLD,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t             r_state;
  logic               r_instrValid;
  logic [31:0]        r_instr;
  logic [31:0]        r_instrPC;
  logic               r_fetchTimeout;
  logic [CNT_W-1:0]   r_waitCnt;
  logic [31:0]        r_reqAddr;

  logic               w_req;
  logic [31:0]        w_addr;
  logic               w_redir;
  logic               w_ack;
  logic               w_miss;
  logic               w_timeout;
  logic               w_count;
  logic [31:0]        w_newPC;

  always_comb begin
    w_req   = 1'b0;
    w_addr  = '0;
    w_redir = 1'b0;
    case (r_state)
      S_FETCH: begin
        // A full buffer that decode is refusing must not be overwritten.
        w_req   = !(r_instrValid && stall);
        w_addr  = pcAddress;
        w_redir = redirect || exception;
      end
      S_HOLD: begin
        w_redir = redirect || exception;
      end
      S_DRAIN: begin
        // PC has already moved; keep presenting the abandoned address.
        w_req   = 1'b1;
        w_addr  = r_reqAddr;
        w_redir = redirect || exception;
      end
      default: ;
    endcase
    w_ack     = w_req && imemAck;
    w_miss    = w_req && !imemAck;
    w_timeout = w_miss && (r_waitCnt == WAIT_LAST);
    // Advancing while loading would land the PC on target+4.
    w_count   = (r_state == S_FETCH) && w_ack && !w_redir;
    w_newPC   = w_redir ? (exception ? EXC_VECTOR : redirectTarget) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_RESET;
      r_instrValid   <= 1'b0;
      r_instr        <= '0;
      r_instrPC      <= '0;
      r_fetchTimeout <= 1'b0;
      r_waitCnt      <= '0;
      r_reqAddr      <= '0;
    end else if (w_timeout) begin
      r_state        <= S_HALT;
      r_fetchTimeout <= 1'b1;
      r_instrValid   <= 1'b0;
      r_waitCnt      <= '0;
    end else begin
      case (r_state)
        S_RESET: begin
          r_state   <= S_FETCH;
          r_waitCnt <= '0;
        end
        S_FETCH: begin
          r_reqAddr <= pcAddress;
          if (w_redir) begin
            r_instrValid <= 1'b0;
            r_waitCnt    <= '0;
            r_state      <= w_miss ? S_DRAIN : S_FETCH;
          end else if (w_ack) begin
            r_instr      <= imemData;
            r_instrPC    <= pcAddress;
            r_instrValid <= 1'b1;
            r_waitCnt    <= '0;
          end else begin
            if (!stall) r_instrValid <= 1'b0;
            r_waitCnt <= w_miss ? r_waitCnt + CNT_ONE : '0;
            if (r_instrValid && stall) begin
              r_state   <= S_HOLD;
              r_waitCnt <= '0;
            end
          end
        end
        S_HOLD: begin
          if (w_redir || !stall) begin
            r_instrValid <= 1'b0;
            r_state      <= S_FETCH;
          end
        end
        S_DRAIN: begin
          // Ack here returns stale data, which is simply dropped.
          if (w_ack) begin
            r_state   <= S_FETCH;
            r_waitCnt <= '0;
          end else begin
            r_waitCnt <= r_waitCnt + CNT_ONE;
          end
        end
        S_HALT: begin
          r_instrValid <= 1'b0;
        end
        default: begin
          r_state <= S_RESET;
        end
      endcase
    end
  end

  assign count          = w_count;
  assign shouldUseNewPC = w_redir;
  assign newPC          = w_newPC;
  assign imemReq        = w_req;
  assign imemAddr       = w_addr;
  assign instrValid     = r_instrValid;
  assign instr          = r_instr;
  assign instrPC        = r_instrPC;
  assign fetchTimeout   = r_fetchTimeout;

endmodule
